// File: rtl/vld_order_checker.sv
// Ordered-fill checker for a sticky per-lane valid vector: lanes must appear
// lowest first, one per cycle at most, within a stall budget.
module vld_order_checker #(
    parameter int SIZE    = 8,
    parameter int TIMEOUT = 16,
    parameter int IW      = $clog2(SIZE),
    parameter int CW      = $clog2(SIZE * (TIMEOUT + 1) + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] vld_in,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [1:0]      err_code,
    output logic [IW-1:0]   err_idx,
    output logic [CW-1:0]   cycles
);

    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [IW:0]   LAST_IDX   = (IW + 1)'(SIZE - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_ORDER   = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT = 2'd2;
    localparam logic [1:0] CODE_PRESET  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t          r_state;
    logic [SIZE-1:0] r_exp;
    logic [IW:0]     r_idx;
    logic [SW-1:0]   r_stall;
    logic [CW-1:0]   r_cycles;
    logic [1:0]      r_errCode;
    logic [IW-1:0]   r_errIdx;
    logic            r_busy;
    logic            r_done;
    logic            r_error;

    logic [SIZE-1:0] w_lane;
    logic [SIZE-1:0] w_next;
    logic [IW-1:0]   w_idxLow;
    logic [CW-1:0]   w_cyclesNext;

    // The only acceptable new value is the expected mask plus the next lane.
    assign w_lane       = {{(SIZE-1){1'b0}}, 1'b1} << r_idx;
    assign w_next       = r_exp | w_lane;
    assign w_idxLow     = r_idx[IW-1:0];
    assign w_cyclesNext = (&r_cycles) ? r_cycles : r_cycles + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_exp     <= '0;
            r_idx     <= '0;
            r_stall   <= '0;
            r_cycles  <= '0;
            r_errCode <= CODE_NONE;
            r_errIdx  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        if (|vld_in) begin
                            r_state   <= ST_FAIL;
                            r_errCode <= CODE_PRESET;
                            r_errIdx  <= '0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b0;
                            r_error   <= 1'b1;
                        end else begin
                            r_state   <= ST_SCAN;
                            r_exp     <= '0;
                            r_idx     <= '0;
                            r_stall   <= '0;
                            r_cycles  <= '0;
                            r_errCode <= CODE_NONE;
                            r_busy    <= 1'b1;
                            r_done    <= 1'b0;
                            r_error   <= 1'b0;
                        end
                    end
                end
                ST_SCAN: begin
                    r_cycles <= w_cyclesNext;
                    if (vld_in == r_exp) begin
                        r_stall <= r_stall + SW'(1);
                        if (r_stall == STALL_LAST) begin
                            r_state   <= ST_FAIL;
                            r_errCode <= CODE_TIMEOUT;
                            r_errIdx  <= w_idxLow;
                            r_busy    <= 1'b0;
                            r_error   <= 1'b1;
                        end
                    end else if (vld_in == w_next) begin
                        // Progress always beats a stall limit reached on the same edge.
                        r_exp   <= w_next;
                        r_idx   <= r_idx + (IW + 1)'(1);
                        r_stall <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state   <= ST_FAIL;
                        r_errCode <= CODE_ORDER;
                        r_errIdx  <= w_idxLow;
                        r_busy    <= 1'b0;
                        r_error   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_errCode;
    assign err_idx  = r_errIdx;
    assign cycles   = r_cycles;

endmodule

// File: tb/tb_vld_order_checker.sv
// Scoreboard bench for vld_order_checker: directed cases with fixed expectations
// followed by random fills scored against a lane-counting reference model.
module tb_vld_order_checker;

    localparam int SIZE    = 8;
    localparam int TIMEOUT = 4;
    localparam int IW      = $clog2(SIZE);
    localparam int CW      = $clog2(SIZE * (TIMEOUT + 1) + 1);

    typedef struct {
        bit       isDone;
        bit [1:0] code;
        int       errIdx;
        int       cycles;
        int       edgeNum;
        string    tag;
    } result_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [SIZE-1:0] vld_in;
    logic            busy;
    logic            done;
    logic            error;
    logic [1:0]      err_code;
    logic [IW-1:0]   err_idx;
    logic [CW-1:0]   cycles;

    int         compared   = 0;
    int         mismatched = 0;
    int         edgeCount  = 0;
    result_t    expQ[$];
    logic [7:0] stimQ[$];

    int mdlCycles     = 0;
    int mdlErrIdx     = 0;
    bit mdlLastPreset = 0;

    bit       prevBusy  = 0;
    bit       prevDone  = 0;
    bit       prevError = 0;
    bit [1:0] prevCode  = 0;

    vld_order_checker #(
        .SIZE    (SIZE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .vld_in   (vld_in),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .err_idx  (err_idx),
        .cycles   (cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edgeCount <= edgeCount + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, required);
        end
    endtask

    function automatic result_t mkRes(input bit isDone, input bit [1:0] code, input int idx,
                                      input int cyc, input int edgeRel);
        result_t r;
        r.isDone  = isDone;
        r.code    = code;
        r.errIdx  = idx;
        r.cycles  = cyc;
        r.edgeNum = edgeRel;
        r.tag     = "";
        return r;
    endfunction

    // Reference model: counts accepted lanes and treats each vector as a number
    // that must equal 2^seen-1 (stall) or 2^(seen+1)-1 (next lane).
    function automatic void modelRun(input logic [7:0] startVec, output result_t res,
                                     output int usedLen);
        int seen     = 0;
        int stallCnt = 0;
        int satMax   = (1 << CW) - 1;
        res     = mkRes(0, 0, 0, 0, -1);
        usedLen = stimQ.size();
        if (startVec != 0) begin
            res           = mkRes(0, 3, 0, mdlCycles, 0);
            usedLen       = 0;
            mdlErrIdx     = 0;
            mdlLastPreset = 1;
            return;
        end
        mdlLastPreset = 0;
        for (int k = 0; k < stimQ.size(); k++) begin
            int v   = int'(stimQ[k]);
            int cyc = (k + 1 > satMax) ? satMax : k + 1;
            if (v == (1 << (seen + 1)) - 1) begin
                seen++;
                stallCnt = 0;
                if (seen == SIZE) begin
                    res     = mkRes(1, 0, mdlErrIdx, cyc, k + 1);
                    usedLen = k + 1;
                    break;
                end
            end else if (v == (1 << seen) - 1) begin
                stallCnt++;
                if (stallCnt == TIMEOUT) begin
                    res     = mkRes(0, 2, seen, cyc, k + 1);
                    usedLen = k + 1;
                    break;
                end
            end else begin
                res     = mkRes(0, 1, seen, cyc, k + 1);
                usedLen = k + 1;
                break;
            end
        end
        if (res.edgeNum >= 0) begin
            mdlCycles = res.cycles;
            if (!res.isDone) mdlErrIdx = res.errIdx;
        end
    endfunction

    task automatic fillRandom();
        int  seen = 0;
        bit  stop = 0;
        stimQ.delete();
        for (int n = 0; n < 60 && !stop; n++) begin
            int         r;
            int         j;
            logic [7:0] v;
            r = (n >= 40) ? 0 : $urandom_range(0, 99);
            if (r < 60) begin
                v = 8'((1 << (seen + 1)) - 1);
                seen++;
                if (seen == SIZE) stop = 1;
            end else if (r < 93) begin
                v = 8'((1 << seen) - 1);
            end else begin
                j = $urandom_range(0, SIZE - 1);
                if (j == seen) j = (seen + 1) % SIZE;
                v    = 8'((1 << seen) - 1) ^ 8'(1 << j);
                stop = 1;
            end
            stimQ.push_back(v);
        end
    endtask

    task automatic waitDrain();
        int t = 0;
        while (expQ.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout_pending", expQ.size(), 0);
            expQ.delete();
        end
    endtask

    // startMode: 0 no start during SCAN, 1 start held high, 2 random start pulses.
    task automatic applyStimulus(input string tag, input logic [7:0] startVec,
                                 input int startMode, input result_t expRel);
        result_t e;
        @(negedge clk);
        start     = 1'b1;
        vld_in    = startVec;
        e         = expRel;
        e.edgeNum = expRel.edgeNum + edgeCount + 1;
        e.tag     = tag;
        expQ.push_back(e);
        if (startVec != 0) begin
            @(negedge clk);
            start = 1'b0;
        end else begin
            for (int k = 0; k < stimQ.size(); k++) begin
                @(negedge clk);
                if (k == 0) checkOutput({tag, "_busy_after_start"}, busy, 1);
                vld_in = stimQ[k];
                case (startMode)
                    1:       start = 1'b1;
                    2:       start = ($urandom_range(0, 4) == 0);
                    default: start = 1'b0;
                endcase
            end
            @(negedge clk);
            start = 1'b0;
        end
        waitDrain();
    endtask

    task automatic runDirected(input string tag, input int startMode, input result_t expRel);
        result_t mres;
        int      used;
        modelRun(8'h00, mres, used);
        applyStimulus(tag, 8'h00, startMode, expRel);
    endtask

    // Monitor: a result is presented when done/error appears after SCAN or changes.
    always @(negedge clk) begin
        result_t e;
        if ((done || error) &&
            (prevBusy || !(prevDone || prevError) || prevDone != done || prevCode != err_code)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result_queue", expQ.size(), 1);
            end else begin
                e = expQ.pop_front();
                checkOutput({e.tag, "_done"}, done, e.isDone);
                checkOutput({e.tag, "_error"}, error, !e.isDone);
                checkOutput({e.tag, "_err_code"}, err_code, e.code);
                checkOutput({e.tag, "_err_idx"}, err_idx, e.errIdx);
                checkOutput({e.tag, "_cycles"}, cycles, e.cycles);
                checkOutput({e.tag, "_edge"}, edgeCount, e.edgeNum);
                checkOutput({e.tag, "_busy"}, busy, 0);
            end
        end
        prevBusy  = busy;
        prevDone  = done;
        prevError = error;
        prevCode  = err_code;
    end

    initial begin
        result_t mres;
        int      used;
        logic [7:0] startVec;

        rst_n  = 1'b0;
        start  = 1'b0;
        vld_in = '0;
        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_error", error, 0);
        checkOutput("reset_err_code", err_code, 0);
        checkOutput("reset_err_idx", err_idx, 0);
        checkOutput("reset_cycles", cycles, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        stimQ = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        runDirected("ideal", 1, mkRes(1, 0, 0, 8, 8));

        stimQ = '{8'h01, 8'h03, 8'h0B};
        runDirected("skip", 1, mkRes(0, 1, 2, 3, 3));

        stimQ = '{8'h01, 8'h03, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07};
        runDirected("stall", 1, mkRes(0, 2, 3, 7, 7));

        stimQ.delete();
        modelRun(8'h01, mres, used);
        applyStimulus("preset", 8'h01, 0, mkRes(0, 3, 0, 7, 0));

        stimQ = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        runDirected("restart", 0, mkRes(1, 0, 0, 8, 8));

        @(negedge clk);
        start  = 1'b1;
        vld_in = '0;
        stimQ  = '{8'h01, 8'h03, 8'h07};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start  = 1'b0;
            vld_in = stimQ[k];
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_error", error, 0);
        checkOutput("midreset_cycles", cycles, 0);
        checkOutput("midreset_err_code", err_code, 0);
        @(negedge clk);
        vld_in = '0;
        @(negedge clk);
        rst_n         = 1'b1;
        mdlCycles     = 0;
        mdlErrIdx     = 0;
        mdlLastPreset = 0;

        stimQ = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        runDirected("after_reset", 2, mkRes(1, 0, 0, 8, 8));

        stimQ = '{8'h03};
        runDirected("double", 0, mkRes(0, 1, 0, 1, 1));

        stimQ = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        runDirected("stall_edge_bit", 1, mkRes(1, 0, 0, 11, 11));

        for (int t = 0; t < 40; t++) begin
            startVec = 8'h00;
            if (!mdlLastPreset && $urandom_range(0, 9) == 0) startVec = 8'($urandom_range(1, 255));
            if (startVec != 0) begin
                stimQ.delete();
            end else begin
                fillRandom();
            end
            modelRun(startVec, mres, used);
            while (stimQ.size() > used) void'(stimQ.pop_back());
            applyStimulus($sformatf("rand%0d", t), startVec, 2, mres);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
